// File: rtl/count_sequencer_pkg.sv
// Shared types for the run/pause/load count sequencer: state encoding and the
// start-button transition map.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // DONE is sticky against start; only a load leaves it.
  function automatic state_e start_next(input state_e s);
    case (s)
      ST_IDLE:  return ST_RUN;
      ST_RUN:   return ST_PAUSE;
      ST_PAUSE: return ST_RUN;
      default:  return ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Key/switch inputs, counter feedback and strobe/status outputs of the count sequencer.
interface count_sequencer_if #(
  parameter int WIDTH = 4
);
  import count_sequencer_pkg::*;

  logic             key_start_n;
  logic             key_load_n;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             cnt_load;
  logic             cnt_en;
  logic             busy;
  logic             done;
  state_e           state;

  modport master (
    output key_start_n, key_load_n, limit, q,
    input  cnt_load, cnt_en, busy, done, state
  );

  modport slave (
    input  key_start_n, key_load_n, limit, q,
    output cnt_load, cnt_en, busy, done, state
  );

endinterface

// File: rtl/count_sequencer_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, symmetric stability counter and a
// single-cycle pulse when a press is accepted.
module count_sequencer_key_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);
  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counter only runs while the synchronised key disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/load controller for the loadable up-counter: debounced keys, tick
// prescaler and one-cycle load/increment strobes up to a terminal value.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 50000000,
  parameter int DEBOUNCE = 500000
) (
  input logic              clk,
  input logic              rst_n,
  count_sequencer_if.slave bus
);
  localparam int            PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [1:0]       key_n;
  logic [1:0]       press;
  logic             start_p, load_p;
  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             busy_q, done_q;
  logic             cnt_load, cnt_en, tick;
  logic [WIDTH-1:0] q_w, limit_w;

  assign key_n   = {bus.key_load_n, bus.key_start_n};
  assign q_w     = bus.q;
  assign limit_w = bus.limit;

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    count_sequencer_key_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key_n[gi]),
      .press_p(press[gi])
    );
  end

  assign start_p = press[0];
  assign load_p  = press[1];

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    tick     = (presc_q == PRESC_LAST);
    if (load_p) begin
      cnt_load = 1'b1;
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          // The prescaler keeps counting in the cycle a pause is requested.
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick && (q_w != limit_w)) cnt_en = 1'b1;
          if (tick && (q_w == limit_w)) state_d = ST_DONE;
          else if (start_p)             state_d = start_next(state_q);
        end
        ST_PAUSE: begin
          if (start_p) state_d = start_next(state_q);
        end
        default: begin
          presc_d = '0;
          if (start_p) state_d = start_next(state_q);
        end
      endcase
    end
    // Strobes are suppressed while reset is asserted so the counter never moves on a reset edge.
    if (!rst_n) begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.cnt_load = cnt_load;
  assign bus.cnt_en   = cnt_en;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: behavioural 4-bit counter, strobe scoreboard,
// vector table of load/limit runs and hand-written timing sequences.
module tb_count_sequencer;
  import count_sequencer_pkg::*;

  typedef struct packed {
    logic       is_load;
    logic [3:0] q;
  } ev_t;

  typedef struct {
    logic [3:0] ld;
    logic [3:0] lim;
    int         n_inc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] load_val;
  logic [3:0] model_q = 4'd0;
  logic [3:0] qq, q_p, q_r;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         en_seen = 0;
  int         en0, n, load_at;
  ev_t        exp_q[$];
  vec_t       vecs[5];

  count_sequencer_if #(.WIDTH(4)) bus ();

  count_sequencer #(
    .WIDTH   (4),
    .PRESCALE(4),
    .DEBOUNCE(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cnt_load)    model_q <= load_val;
    else if (bus.cnt_en) model_q <= model_q + 4'd1;
  end
  assign bus.q = model_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; samples 1 time unit after the edge and scores any strobe.
  task automatic step();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cnt_load && bus.cnt_en) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_overlap: cnt_load=1 cnt_en=1, required at most one (cyc %0d)", cyc);
    end
    if (bus.cnt_en) begin
      en_seen++;
      chk("en_only_in_run", 32'(bus.state), 32'(ST_RUN));
    end
    if (bus.cnt_load || bus.cnt_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: load=%0b en=%0b, required none (cyc %0d)",
                 bus.cnt_load, bus.cnt_en, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("cyc %0d: %s strobe, q=%0d", cyc, bus.cnt_load ? "load" : "inc", bus.q);
        chk("strobe_kind", 32'(bus.cnt_load), 32'(e.is_load));
        if (!e.is_load) chk("inc_from_q", 32'(bus.q), 32'(e.q));
      end
    end
  endtask

  task automatic press(input bit ld, input bit st, input int hold);
    if (ld) bus.key_load_n = 1'b0;
    if (st) bus.key_start_n = 1'b0;
    repeat (hold) step();
    bus.key_load_n  = 1'b1;
    bus.key_start_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic wait_state(input state_e s, input int budget, output int cnt);
    cnt = 0;
    while (bus.state != s && cnt < budget) begin
      step();
      cnt++;
    end
    chk("wait_state", 32'(bus.state), 32'(s));
  endtask

  task automatic wait_en(input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!bus.cnt_en && cnt < budget);
    chk("wait_en", 32'(bus.cnt_en), 32'd1);
  endtask

  task automatic wait_q_change(input int budget, output int cnt);
    logic [3:0] q0;
    q0  = model_q;
    cnt = 0;
    while (model_q == q0 && cnt < budget) begin
      step();
      cnt++;
    end
    chk("wait_q_change", 32'(model_q != q0), 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'd3,  4'd5,  2};
    vecs[1] = '{4'd14, 4'd1,  3};
    vecs[2] = '{4'd7,  4'd7,  0};
    vecs[3] = '{4'd9,  4'd2,  9};
    vecs[4] = '{4'd12, 4'd11, 15};

    rst_n           = 1'b0;
    bus.key_start_n = 1'b1;
    bus.key_load_n  = 1'b1;
    bus.limit       = 4'd0;
    load_val        = 4'd0;

    // Reset state, then quiet idle.
    step();
    step();
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("rst_cnt_load", 32'(bus.cnt_load), 32'd0);
    chk("rst_cnt_en", 32'(bus.cnt_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_state", 32'(bus.state), 32'(ST_IDLE));

    // Single load press: pulse 5 samples after the key falls.
    load_val = 4'd3;
    exp_q.push_back('{1'b1, 4'd0});
    bus.key_load_n = 1'b0;
    load_at = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.cnt_load) load_at = i;
    end
    bus.key_load_n = 1'b1;
    repeat (6) step();
    chk("load_latency", 32'(load_at), 32'd5);
    chk("load_q", 32'(model_q), 32'd3);
    chk("load_state", 32'(bus.state), 32'(ST_IDLE));
    chk("load_sb_drained", 32'(exp_q.size()), 32'd0);

    // Bouncing keys must not be accepted.
    for (int i = 0; i < 3; i++) begin
      bus.key_start_n = 1'b0;
      bus.key_load_n  = 1'b0;
      repeat (2) step();
      bus.key_start_n = 1'b1;
      bus.key_load_n  = 1'b1;
      repeat (2) step();
    end
    repeat (8) step();
    chk("bounce_state", 32'(bus.state), 32'(ST_IDLE));
    chk("bounce_q", 32'(model_q), 32'd3);

    // Simultaneous presses: load wins, start is dropped.
    load_val = 4'd9;
    exp_q.push_back('{1'b1, 4'd0});
    press(1'b1, 1'b1, 6);
    chk("both_state", 32'(bus.state), 32'(ST_IDLE));
    chk("both_q", 32'(model_q), 32'd9);
    chk("both_sb_drained", 32'(exp_q.size()), 32'd0);

    // Vector table: load, start, run to terminal value.
    for (int r = 0; r < 5; r++) begin
      load_val  = vecs[r].ld;
      bus.limit = vecs[r].lim;
      exp_q.push_back('{1'b1, 4'd0});
      press(1'b1, 1'b0, 6);
      chk("vec_load_q", 32'(model_q), 32'(vecs[r].ld));
      en0 = en_seen;
      qq  = vecs[r].ld;
      for (int i = 0; i < vecs[r].n_inc; i++) begin
        exp_q.push_back('{1'b0, qq});
        qq = qq + 4'd1;
      end
      press(1'b0, 1'b1, 6);
      wait_state(ST_DONE, vecs[r].n_inc * 4 + 20, n);
      chk("vec_final_q", 32'(model_q), 32'(vecs[r].lim));
      chk("vec_n_inc", 32'(en_seen - en0), 32'(vecs[r].n_inc));
      chk("vec_done", 32'(bus.done), 32'd1);
      chk("vec_busy", 32'(bus.busy), 32'd0);
      chk("vec_sb_drained", 32'(exp_q.size()), 32'd0);
      if (r == 0) begin
        press(1'b0, 1'b1, 6);
        chk("done_ignores_start", 32'(bus.state), 32'(ST_DONE));
      end
    end

    // Pause/resume timing.
    load_val  = 4'd0;
    bus.limit = 4'd15;
    exp_q.push_back('{1'b1, 4'd0});
    press(1'b1, 1'b0, 6);
    for (int i = 0; i < 15; i++) exp_q.push_back('{1'b0, 4'(i)});
    bus.key_start_n = 1'b0;
    wait_state(ST_RUN, 12, n);
    chk("start_latency", 32'(n), 32'd6);
    chk("run_busy", 32'(bus.busy), 32'd1);
    wait_q_change(10, n);
    chk("first_inc_latency", 32'(n), 32'd4);
    bus.key_start_n = 1'b1;
    wait_en(10, n);
    wait_en(10, n);
    chk("en_period", 32'(n), 32'd4);
    step();
    bus.key_start_n = 1'b0;
    wait_state(ST_PAUSE, 12, n);
    chk("pause_latency", 32'(n), 32'd6);
    q_p = model_q;
    bus.key_start_n = 1'b1;
    repeat (20) step();
    chk("pause_state", 32'(bus.state), 32'(ST_PAUSE));
    chk("pause_q_held", 32'(model_q), 32'(q_p));
    chk("pause_busy", 32'(bus.busy), 32'd0);
    bus.key_start_n = 1'b0;
    wait_state(ST_RUN, 12, n);
    chk("resume_latency", 32'(n), 32'd6);
    wait_q_change(10, n);
    chk("resume_inc_latency", 32'(n), 32'd2);
    bus.key_start_n = 1'b1;

    // Reset asserted during a tick cycle.
    wait_en(10, n);
    repeat (3) step();
    exp_q.delete();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tick_no_en", 32'(bus.cnt_en), 32'd0);
    chk("rst_tick_no_load", 32'(bus.cnt_load), 32'd0);
    q_r = model_q;
    step();
    chk("midrun_rst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
    chk("midrun_rst_q", 32'(model_q), 32'(q_r));
    rst_n = 1'b1;
    repeat (10) step();
    chk("post_rst_idle", 32'(bus.state), 32'(ST_IDLE));
    exp_q.push_back('{1'b0, q_r});
    bus.key_start_n = 1'b0;
    wait_state(ST_RUN, 12, n);
    wait_q_change(10, n);
    chk("post_rst_inc_latency", 32'(n), 32'd4);
    bus.key_start_n = 1'b1;
    chk("final_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
